// File: rtl/bsg_manycore_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_manycore_pkg
//  Description : Shared width helpers for manycore link packets. Packets are
//                carried as flat vectors; these functions give their widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package bsg_manycore_pkg;

    // Request: op(2) + byte mask + EPA + payload + source and destination coords.
    function automatic int packet_width(input int addr_w, input int data_w,
                                        input int x_w, input int y_w);
        return 2 + (data_w / 8) + addr_w + data_w + 2 * (x_w + y_w);
    endfunction

    // Response: type(2) + payload + load id + destination coords.
    function automatic int return_packet_width(input int data_w, input int load_id_w,
                                               input int x_w, input int y_w);
        return 2 + data_w + load_id_w + x_w + y_w;
    endfunction

    // Link layout, MSB first:
    //   {fwd.v, fwd.data, fwd.ready_and_rev, rev.v, rev.data, rev.ready_and_rev}
    function automatic int link_sif_width(input int pkt_w, input int ret_w);
        return pkt_w + ret_w + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_manycore_ep_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_manycore_ep_fifo
//  Description : Circular buffer with read/write pointers and wrap bits.
//                Head is visible the cycle after it is written. Optionally
//                accepts a new entry while full if the head leaves that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_manycore_ep_fifo
    import bsg_manycore_pkg::*;
#(
    parameter int WIDTH_P                 = 8,
    parameter int ELS_P                   = 4,
    parameter bit ALLOW_ENQ_DEQ_ON_FULL_P = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_v,
    input  logic [WIDTH_P-1:0] i_data,
    output logic               o_ready,
    output logic               o_v,
    output logic [WIDTH_P-1:0] o_data,
    input  logic               i_yumi
);
    localparam int                 c_ptr_w = (ELS_P > 1) ? $clog2(ELS_P) : 1;
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(ELS_P - 1);

    logic [WIDTH_P-1:0] r_mem [ELS_P];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic               r_rd_wrap;
    logic               r_wr_wrap;
    logic               w_empty;
    logic               w_full;
    logic               w_enq;
    logic               w_deq;

    assign w_empty = (r_rd_ptr == r_wr_ptr) && (r_rd_wrap == r_wr_wrap);
    assign w_full  = (r_rd_ptr == r_wr_ptr) && (r_rd_wrap != r_wr_wrap);
    assign w_deq   = i_yumi & ~w_empty;

    generate
        if (ALLOW_ENQ_DEQ_ON_FULL_P) begin : g_enq_on_full
            // The slot being written is the one the head vacates this cycle.
            assign w_enq = i_v & (~w_full | w_deq);
        end else begin : g_enq_not_full
            assign w_enq = i_v & ~w_full;
        end
    endgenerate

    assign o_ready = ~w_full;
    assign o_v     = ~w_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and wrap-bit advance; the wrap bits disambiguate full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rd_wrap <= 1'b0;
            r_wr_wrap <= 1'b0;
        end else begin
            if (w_enq) begin
                if (r_wr_ptr == c_last) begin
                    r_wr_ptr  <= '0;
                    r_wr_wrap <= ~r_wr_wrap;
                end else begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
            end
            if (w_deq) begin
                if (r_rd_ptr == c_last) begin
                    r_rd_ptr  <= '0;
                    r_rd_wrap <= ~r_rd_wrap;
                end else begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_endpoint_credited.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_manycore_endpoint_credited
//  Description : Tile-side manycore link endpoint with buffered incoming
//                requests/responses and an outstanding-request credit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_manycore_endpoint_credited
    import bsg_manycore_pkg::*;
#(
    parameter int X_CORD_WIDTH_P    = 4,
    parameter int Y_CORD_WIDTH_P    = 4,
    parameter int DATA_WIDTH_P      = 32,
    parameter int ADDR_WIDTH_P      = 16,
    parameter int LOAD_ID_WIDTH_P   = 5,
    parameter int REQ_FIFO_ELS_P    = 4,
    parameter int RET_FIFO_ELS_P    = 4,
    parameter int MAX_OUT_CREDITS_P = 16,
    parameter bit GUARANTEE_RET_P   = 1'b1,
    localparam int c_pkt_w    = packet_width(ADDR_WIDTH_P, DATA_WIDTH_P, X_CORD_WIDTH_P, Y_CORD_WIDTH_P),
    localparam int c_ret_w    = return_packet_width(DATA_WIDTH_P, LOAD_ID_WIDTH_P, X_CORD_WIDTH_P, Y_CORD_WIDTH_P),
    localparam int c_link_w   = link_sif_width(c_pkt_w, c_ret_w),
    localparam int c_credit_w = $clog2(MAX_OUT_CREDITS_P + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [c_link_w-1:0]   link_sif_i,
    output logic [c_link_w-1:0]   link_sif_o,
    output logic [c_pkt_w-1:0]    packet_o,
    output logic                  packet_v_o,
    input  logic                  packet_yumi_i,
    input  logic                  return_packet_v_i,
    input  logic [c_ret_w-1:0]    return_packet_i,
    output logic                  return_packet_ready_o,
    input  logic                  packet_v_i,
    input  logic [c_pkt_w-1:0]    packet_i,
    output logic                  packet_ready_o,
    output logic                  return_packet_v_o,
    output logic [c_ret_w-1:0]    return_packet_o,
    input  logic                  return_packet_yumi_i,
    output logic                  return_fifo_full_o,
    output logic [c_credit_w-1:0] out_credits_o,
    output logic                  ret_overflow_o
);
    // Capping outstanding requests at the response depth means every response
    // that can arrive already has a buffer slot reserved.
    localparam int c_lim = (GUARANTEE_RET_P && (RET_FIFO_ELS_P < MAX_OUT_CREDITS_P))
                           ? RET_FIFO_ELS_P : MAX_OUT_CREDITS_P;
    localparam logic [c_credit_w-1:0] c_lim_cnt = c_credit_w'(c_lim);

    logic                  w_in_fwd_v;
    logic [c_pkt_w-1:0]    w_in_fwd_data;
    logic                  w_in_fwd_ready;
    logic                  w_in_rev_v;
    logic [c_ret_w-1:0]    w_in_rev_data;
    logic                  w_in_rev_ready;
    logic                  w_req_ready;
    logic                  w_ret_not_full;
    logic                  w_credit_ok;
    logic                  w_out_fwd_v;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_ret_drop;
    logic [c_credit_w-1:0] r_credits;
    logic                  r_ret_overflow;

    assign {w_in_fwd_v, w_in_fwd_data, w_in_fwd_ready,
            w_in_rev_v, w_in_rev_data, w_in_rev_ready} = link_sif_i;

    // Responses are always accepted from the network; overflow is detected locally.
    assign link_sif_o = {w_out_fwd_v, packet_i, w_req_ready,
                         return_packet_v_i, return_packet_i, 1'b1};

    assign return_packet_ready_o = w_in_rev_ready;

    bsg_manycore_ep_fifo #(
        .WIDTH_P                (c_pkt_w),
        .ELS_P                  (REQ_FIFO_ELS_P),
        .ALLOW_ENQ_DEQ_ON_FULL_P(1'b0)
    ) u_req_fifo (
        .clk    (clk_i),
        .rst    (reset_i),
        .i_v    (w_in_fwd_v),
        .i_data (w_in_fwd_data),
        .o_ready(w_req_ready),
        .o_v    (packet_v_o),
        .o_data (packet_o),
        .i_yumi (packet_yumi_i)
    );

    bsg_manycore_ep_fifo #(
        .WIDTH_P                (c_ret_w),
        .ELS_P                  (RET_FIFO_ELS_P),
        .ALLOW_ENQ_DEQ_ON_FULL_P(1'b1)
    ) u_ret_fifo (
        .clk    (clk_i),
        .rst    (reset_i),
        .i_v    (w_in_rev_v),
        .i_data (w_in_rev_data),
        .o_ready(w_ret_not_full),
        .o_v    (return_packet_v_o),
        .o_data (return_packet_o),
        .i_yumi (return_packet_yumi_i)
    );

    assign return_fifo_full_o = ~w_ret_not_full;
    assign w_ret_drop         = w_in_rev_v & ~w_ret_not_full & ~return_packet_yumi_i;

    assign w_credit_ok    = (r_credits < c_lim_cnt);
    assign packet_ready_o = w_in_fwd_ready & w_credit_ok;
    assign w_out_fwd_v    = packet_v_i & w_credit_ok;
    assign w_inc          = packet_v_i & packet_ready_o;
    assign w_dec          = return_packet_yumi_i;
    assign out_credits_o  = r_credits;
    assign ret_overflow_o = r_ret_overflow;

    // Outstanding-request count: up on an issued request, down on a consumed response.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_credits <= '0;
        end else if (w_inc && !w_dec) begin
            r_credits <= r_credits + c_credit_w'(1);
        end else if (!w_inc && w_dec) begin
            r_credits <= r_credits - c_credit_w'(1);
        end
    end

    // Sticky record of any response dropped because the buffer was full.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ret_overflow <= 1'b0;
        end else if (w_ret_drop) begin
            r_ret_overflow <= 1'b1;
        end
    end

    a_no_credit_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(w_dec && !w_inc && (r_credits == '0)))
        else $error("response consumed with no outstanding request");

    a_no_credit_overrun: assert property (@(posedge clk_i) disable iff (reset_i)
        !(w_inc && !w_dec && (r_credits == c_lim_cnt)))
        else $error("request issued beyond the credit limit");

    a_no_ret_drop: assert property (@(posedge clk_i) disable iff (reset_i)
        !w_ret_drop)
        else $warning("response dropped: response buffer full");

endmodule
`default_nettype wire
